// File: rtl/hotspot_pos_ctrl.sv
// hotspot_pos_ctrl
// ----------------
// Sequences position updates to the hotspot overlay renderer. Raw source
// position samples are gated by magnitude into a single-entry latest-wins
// pending buffer. At each frame start (vsync rising edge) the buffer is
// snapshotted, clamped to screen bounds, smoothed with a first-order shift
// filter and committed to the overlay. Commits happen only at frame start,
// so the overlay never moves mid-frame. After TIMEOUT_FRAMES consecutive
// frames without a detection the hotspot is hidden.
//
// Optional feature: define HOTSPOT_DEADBAND_EN to suppress commits whose
// clamped target lies within DEADBAND pixels of the filtered position on
// both axes.
//
// Ports:
//   clk_pix   in   pixel clock, the only clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   sample valid
//   in_ready  out  sample ready (high in HIDDEN and WAIT)
//   in_x/in_y in   raw signed 32-bit coordinates, may lie off-screen
//   in_mag    in   unsigned detection magnitude
//   frame_vs  in   active-high vsync
//   pos_x     out  committed x in [0, H_RES]
//   pos_y     out  committed y in [0, V_RES]
//   pos_ena   out  one-cycle load strobe to the overlay
//   show      out  overlay visible
//   miss_cnt  out  consecutive frames without a detection (saturating)

module hotspot_pos_ctrl #(
    parameter int          H_RES          = 480,
    parameter int          V_RES          = 272,
    parameter int          ALPHA_SHIFT    = 2,
    parameter logic [15:0] MAG_THD        = 16'd256,
    parameter int          TIMEOUT_FRAMES = 30,
    parameter int          DEADBAND       = 2
) (
    input  logic               clk_pix,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] in_x,
    input  logic signed [31:0] in_y,
    input  logic        [15:0] in_mag,
    input  logic               frame_vs,
    output logic signed [31:0] pos_x,
    output logic signed [31:0] pos_y,
    output logic               pos_ena,
    output logic               show,
    output logic        [7:0]  miss_cnt
);

    localparam logic [1:0] ST_HIDDEN = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_FILT   = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

`ifdef HOTSPOT_DEADBAND_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif

    localparam logic signed [33:0] DB_LIM  = 34'(DEADBAND);
    localparam logic        [7:0]  TO_LIM  = 8'(TIMEOUT_FRAMES);

    function automatic logic signed [31:0] clamp(input logic signed [31:0] v,
                                                 input logic signed [31:0] lim);
        if (v < 0)
            return 32'sd0;
        else if (v > lim)
            return lim;
        else
            return v;
    endfunction

    // Arithmetic shift rounds toward negative infinity; the sum always lands
    // in range because both endpoints of the step are already clamped.
    function automatic logic signed [31:0] smooth(input logic signed [31:0] filt,
                                                  input logic signed [33:0] d);
        logic signed [33:0] s;
        s = 34'(filt) + (d >>> ALPHA_SHIFT);
        return s[31:0];
    endfunction

    logic [1:0]         state_q, state_d;
    logic               vs_q;
    logic               in_ready_q, in_ready_d;
    logic               pend_v_q, pend_v_d;
    logic signed [31:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic signed [31:0] snap_x_q, snap_x_d, snap_y_q, snap_y_d;
    logic signed [31:0] filt_x_q, filt_x_d, filt_y_q, filt_y_d;
    logic signed [31:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic               pos_ena_q, pos_ena_d;
    logic               show_q, show_d;
    logic [7:0]         miss_q, miss_d;

    logic               fs, accept, db_hit;
    logic [7:0]         miss_inc;
    logic signed [31:0] tgt_x, tgt_y;
    logic signed [33:0] d_x, d_y;

    assign fs       = frame_vs && !vs_q;
    assign accept   = in_valid && in_ready_q && (in_mag >= MAG_THD);
    assign miss_inc = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;

    assign tgt_x  = clamp(snap_x_q, 32'(H_RES));
    assign tgt_y  = clamp(snap_y_q, 32'(V_RES));
    assign d_x    = 34'(tgt_x) - 34'(filt_x_q);
    assign d_y    = 34'(tgt_y) - 34'(filt_y_q);
    // DB_EN is a constant, so the window compare is pruned in the default build.
    assign db_hit = DB_EN && (d_x <= DB_LIM) && (d_x >= -DB_LIM)
                          && (d_y <= DB_LIM) && (d_y >= -DB_LIM);

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d   = state_q;
        pend_v_d  = pend_v_q;
        pend_x_d  = pend_x_q;
        pend_y_d  = pend_y_q;
        snap_x_d  = snap_x_q;
        snap_y_d  = snap_y_q;
        filt_x_d  = filt_x_q;
        filt_y_d  = filt_y_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        pos_ena_d = 1'b0;
        show_d    = show_q;
        miss_d    = miss_q;

        // Snapshot first, then accept: a sample landing on the fs cycle
        // itself stays pending for the next frame.
        if (fs) begin
            snap_x_d = pend_x_q;
            snap_y_d = pend_y_q;
            pend_v_d = 1'b0;
        end
        if (accept) begin
            pend_x_d = in_x;
            pend_y_d = in_y;
            pend_v_d = 1'b1;
        end

        case (state_q)
            ST_HIDDEN: begin
                if (fs) begin
                    if (pend_v_q) begin
                        // Reappearing hotspot jumps straight to the target.
                        filt_x_d = clamp(pend_x_q, 32'(H_RES));
                        filt_y_d = clamp(pend_y_q, 32'(V_RES));
                        state_d  = ST_COMMIT;
                    end else begin
                        miss_d = miss_inc;
                    end
                end
            end
            ST_WAIT: begin
                if (fs) begin
                    if (pend_v_q) begin
                        state_d = ST_FILT;
                    end else begin
                        miss_d = miss_inc;
                        if (miss_inc >= TO_LIM) begin
                            show_d  = 1'b0;
                            state_d = ST_HIDDEN;
                        end
                    end
                end
            end
            ST_FILT: begin
                if (db_hit) begin
                    miss_d  = 8'd0;
                    show_d  = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    filt_x_d = smooth(filt_x_q, d_x);
                    filt_y_d = smooth(filt_y_q, d_y);
                    state_d  = ST_COMMIT;
                end
            end
            default: begin // ST_COMMIT
                pos_x_d   = filt_x_q;
                pos_y_d   = filt_y_q;
                pos_ena_d = 1'b1;
                show_d    = 1'b1;
                miss_d    = 8'd0;
                state_d   = ST_WAIT;
            end
        endcase

        in_ready_d = (state_d == ST_HIDDEN) || (state_d == ST_WAIT);
    end

    // NOTE: all state, including the pending/snapshot registers, is reset so
    // a mid-frame reset can never leave a stale sample to commit later.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HIDDEN;
            vs_q       <= 1'b0;
            in_ready_q <= 1'b0;
            pend_v_q   <= 1'b0;
            pend_x_q   <= '0;
            pend_y_q   <= '0;
            snap_x_q   <= '0;
            snap_y_q   <= '0;
            filt_x_q   <= '0;
            filt_y_q   <= '0;
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            pos_ena_q  <= 1'b0;
            show_q     <= 1'b0;
            miss_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples
            // pre-edge values regardless of statement order.
            state_q    <= state_d;
            vs_q       <= frame_vs;
            in_ready_q <= in_ready_d;
            pend_v_q   <= pend_v_d;
            pend_x_q   <= pend_x_d;
            pend_y_q   <= pend_y_d;
            snap_x_q   <= snap_x_d;
            snap_y_q   <= snap_y_d;
            filt_x_q   <= filt_x_d;
            filt_y_q   <= filt_y_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            pos_ena_q  <= pos_ena_d;
            show_q     <= show_d;
            miss_q     <= miss_d;
        end
    end

    assign in_ready = in_ready_q;
    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;
    assign pos_ena  = pos_ena_q;
    assign show     = show_q;
    assign miss_cnt = miss_q;

endmodule

// File: tb/tb_hotspot_pos_ctrl.sv
// Directed testbench for hotspot_pos_ctrl with default parameters.
// Inputs change 1 ns after the rising edge; outputs are sampled there too,
// so every observation reflects the edge just taken.

module tb_hotspot_pos_ctrl;

    logic               clk_pix = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_x, in_y;
    logic        [15:0] in_mag;
    logic               frame_vs;
    logic signed [31:0] pos_x, pos_y;
    logic               pos_ena;
    logic               show;
    logic        [7:0]  miss_cnt;

    int vectors     = 0;
    int miscompares = 0;

    hotspot_pos_ctrl dut (
        .clk_pix  (clk_pix),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_y     (in_y),
        .in_mag   (in_mag),
        .frame_vs (frame_vs),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .pos_ena  (pos_ena),
        .show     (show),
        .miss_cnt (miss_cnt)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_x     = '0;
        in_y     = '0;
        in_mag   = '0;
        frame_vs = 1'b0;
        repeat (2) @(posedge clk_pix);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send(input int x, input int y, input int mag);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        in_mag   = 16'(mag);
        tick();
        in_valid = 1'b0;
    endtask

    // Raise vsync for 'hold' cycles, watch 8 cycles; lat = first cycle after
    // the fs cycle showing pos_ena (0 = none), np = number of pulses seen.
    task automatic frame(input int hold, output int lat, output int np);
        lat = 0;
        np  = 0;
        frame_vs = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i >= hold) frame_vs = 1'b0;
            if (pos_ena) begin
                np++;
                if (lat == 0) lat = i;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        frame_vs = 1'b0;
        #2;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        vectors++; if (pos_x !== 32'sd0) begin miscompares++; $display("FAIL rst_pos_x got %0d want 0", pos_x); end
        vectors++; if (pos_y !== 32'sd0) begin miscompares++; $display("FAIL rst_pos_y got %0d want 0", pos_y); end
        vectors++; if (pos_ena !== 1'b0) begin miscompares++; $display("FAIL rst_pos_ena got %b want 0", pos_ena); end
        vectors++; if (show !== 1'b0) begin miscompares++; $display("FAIL rst_show got %b want 0", show); end
        vectors++; if (miss_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_miss got %0d want 0", miss_cnt); end
        do_reset();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_first_commit();
        int lat, np;
        send(100, 50, 1000);
        frame(1, lat, np);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL first_latency got %0d want 2", lat); end
        vectors++; if (np !== 1) begin miscompares++; $display("FAIL first_pulses got %0d want 1", np); end
        vectors++; if (pos_x !== 32'sd100 || pos_y !== 32'sd50) begin miscompares++; $display("FAIL first_pos got (%0d,%0d) want (100,50)", pos_x, pos_y); end
        vectors++; if (show !== 1'b1) begin miscompares++; $display("FAIL first_show got %b want 1", show); end
    endtask

    task automatic test_smoothing();
        int lat, np;
        send(200, 10, 1000);
        frame_vs = 1'b1;
        tick();
        frame_vs = 1'b0;
        // Now in FILT: ready must be low.
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL filt_in_ready got %b want 0", in_ready); end
        lat = 0;
        for (int i = 2; i <= 6; i++) begin
            tick();
            if (pos_ena && lat == 0) lat = i;
        end
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL smooth_latency got %0d want 3", lat); end
        vectors++; if (pos_x !== 32'sd125 || pos_y !== 32'sd40) begin miscompares++; $display("FAIL smooth_pos got (%0d,%0d) want (125,40)", pos_x, pos_y); end
        np = 0;
    endtask

    task automatic test_latest_wins_clamp();
        int lat, np;
        do_reset();
        send(-20, 300, 1000);
        send(600, -5, 1000);
        frame(1, lat, np);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL clamp_latency got %0d want 2", lat); end
        vectors++; if (pos_x !== 32'sd480 || pos_y !== 32'sd0) begin miscompares++; $display("FAIL clamp_pos got (%0d,%0d) want (480,0)", pos_x, pos_y); end
    endtask

    task automatic test_timeout();
        int lat, np, total;
        total = 0;
        send(5, 5, 100);
        for (int f = 1; f <= 30; f++) begin
            frame(1, lat, np);
            total += np;
            if (f == 29) begin
                vectors++; if (miss_cnt !== 8'd29) begin miscompares++; $display("FAIL to_miss29 got %0d want 29", miss_cnt); end
                vectors++; if (show !== 1'b1) begin miscompares++; $display("FAIL to_show29 got %b want 1", show); end
            end
        end
        vectors++; if (miss_cnt !== 8'd30) begin miscompares++; $display("FAIL to_miss30 got %0d want 30", miss_cnt); end
        vectors++; if (show !== 1'b0) begin miscompares++; $display("FAIL to_show30 got %b want 0", show); end
        vectors++; if (pos_x !== 32'sd480 || pos_y !== 32'sd0) begin miscompares++; $display("FAIL to_pos_hold got (%0d,%0d) want (480,0)", pos_x, pos_y); end
        vectors++; if (total !== 0) begin miscompares++; $display("FAIL to_no_ena got %0d want 0", total); end
        frame(1, lat, np);
        vectors++; if (miss_cnt !== 8'd31) begin miscompares++; $display("FAIL hidden_miss got %0d want 31", miss_cnt); end
        for (int f = 0; f < 230; f++) frame(1, lat, np);
        vectors++; if (miss_cnt !== 8'd255) begin miscompares++; $display("FAIL miss_saturate got %0d want 255", miss_cnt); end
    endtask

    task automatic test_same_cycle_and_held_vs();
        int lat, np;
        // Sample on the fs cycle itself must not be in this frame's snapshot.
        frame_vs = 1'b1;
        in_valid = 1'b1;
        in_x = 300;
        in_y = 200;
        in_mag = 16'd1000;
        tick();
        in_valid = 1'b0;
        frame_vs = 1'b0;
        np = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (pos_ena) np++;
        end
        vectors++; if (np !== 0) begin miscompares++; $display("FAIL samecyc_no_ena got %0d want 0", np); end
        vectors++; if (show !== 1'b0) begin miscompares++; $display("FAIL samecyc_show got %b want 0", show); end
        frame(1, lat, np);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL samecyc_next_latency got %0d want 2", lat); end
        vectors++; if (pos_x !== 32'sd300 || pos_y !== 32'sd200) begin miscompares++; $display("FAIL samecyc_pos got (%0d,%0d) want (300,200)", pos_x, pos_y); end
        // vsync held for 5 cycles: one edge, one commit.
        send(304, 204, 1000);
        frame(5, lat, np);
        vectors++; if (np !== 1) begin miscompares++; $display("FAIL held_vs_pulses got %0d want 1", np); end
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL held_vs_latency got %0d want 3", lat); end
        vectors++; if (pos_x !== 32'sd301 || pos_y !== 32'sd201) begin miscompares++; $display("FAIL held_vs_pos got (%0d,%0d) want (301,201)", pos_x, pos_y); end
    endtask

    task automatic test_negative_rounding();
        int lat, np;
        // (298-301)>>>2 = -1, not 0: rounding toward negative infinity.
        send(298, 201, 1000);
        frame(1, lat, np);
        vectors++; if (pos_x !== 32'sd300 || pos_y !== 32'sd201) begin miscompares++; $display("FAIL neg_round_pos got (%0d,%0d) want (300,201)", pos_x, pos_y); end
    endtask

    task automatic test_reset_in_filt();
        int lat, np;
        send(0, 0, 1000);
        frame_vs = 1'b1;
        tick();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rf_in_filt_ready got %b want 0", in_ready); end
        rst_n = 1'b0;
        #1;
        vectors++; if (pos_x !== 32'sd0 || pos_y !== 32'sd0) begin miscompares++; $display("FAIL rf_pos got (%0d,%0d) want (0,0)", pos_x, pos_y); end
        vectors++; if (show !== 1'b0 || miss_cnt !== 8'd0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL rf_outputs show=%b miss=%0d ready=%b want 0/0/0", show, miss_cnt, in_ready); end
        frame_vs = 1'b0;
        np = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (pos_ena) np++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pos_ena) np++;
        end
        vectors++; if (np !== 0) begin miscompares++; $display("FAIL rf_no_ena got %0d want 0", np); end
        frame(1, lat, np);
        vectors++; if (lat !== 0 || show !== 1'b0 || miss_cnt !== 8'd1) begin miscompares++; $display("FAIL rf_after lat=%0d show=%b miss=%0d want 0/0/1", lat, show, miss_cnt); end
    endtask

`ifdef HOTSPOT_DEADBAND_EN
    task automatic test_deadband();
        int lat, np;
        send(100, 50, 1000);
        frame(1, lat, np);
        frame(1, lat, np);
        vectors++; if (miss_cnt !== 8'd1) begin miscompares++; $display("FAIL db_pre_miss got %0d want 1", miss_cnt); end
        send(101, 49, 1000);
        frame(1, lat, np);
        vectors++; if (np !== 0) begin miscompares++; $display("FAIL db_no_ena got %0d want 0", np); end
        vectors++; if (miss_cnt !== 8'd0 || show !== 1'b1) begin miscompares++; $display("FAIL db_state miss=%0d show=%b want 0/1", miss_cnt, show); end
        vectors++; if (pos_x !== 32'sd100 || pos_y !== 32'sd50) begin miscompares++; $display("FAIL db_pos got (%0d,%0d) want (100,50)", pos_x, pos_y); end
    endtask
`endif

    initial begin
        test_reset();
        test_first_commit();
        test_smoothing();
        test_latest_wins_clamp();
        test_timeout();
        test_same_cycle_and_held_vs();
        test_negative_rounding();
        test_reset_in_filt();
`ifdef HOTSPOT_DEADBAND_EN
        test_deadband();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
